lat_meas_seq: RTL and testbench

Sequencer for the `lat_tester` latency-measurement datapath. On a single start request it runs a programmable number of back-to-back latency measurements. For each run it drives `active`, `armed` and `trigger`, then collects `lat_result` and `stb_result`. It accumulates min, max and sum statistics and reports a completed or failed sequence to the control CPU. It sits between the CPU register interface and `lat_tester`, in the `clk27` domain.

---
 rtl/lat_meas_seq.sv | 145 ++++++++++++++
 tb/tb_lat_meas_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lat_meas_seq.sv
// Sequencer for lat_tester: runs num_runs back-to-back latency measurements and accumulates min/max/sum.
// Optional stabilisation-time statistics (stb_min/stb_max) are built when LT_STB_STATS_EN is defined.
module lat_meas_seq #(
  parameter int GAP_CYCLES   = 2700000,
  parameter int TRIG_TIMEOUT = 8
) (
  input  logic        clk27,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  num_runs,
  output logic        lt_active,
  output logic        lt_armed,
  output logic        lt_trigger,
  input  logic        lt_trig_waiting,
  input  logic        lt_finished,
  input  logic [15:0] lt_lat_result,
  input  logic [11:0] lt_stb_result,
  output logic        busy,
  output logic        done,
  output logic        err_trig,
  output logic        err_sat,
  output logic [3:0]  runs_done,
  output logic [15:0] lat_min,
  output logic [15:0] lat_max,
  output logic [19:0] lat_sum
`ifdef LT_STB_STATS_EN
  ,
  output logic [11:0] stb_min,
  output logic [11:0] stb_max
`endif
);

  localparam int CMAX = (GAP_CYCLES > TRIG_TIMEOUT) ? GAP_CYCLES : TRIG_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, ARM, TRIG, WAIT_FIN, COLLECT, GAP, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [3:0]      runs_tgt;
  logic            lat_sat;
  logic            act_nxt, arm_nxt, trig_nxt, busy_nxt, done_nxt;

  assign lat_sat = (lt_lat_result == 16'hffff);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = ARM;
      ARM:        if (cnt == CW'(1)) state_nxt = TRIG;
      TRIG: begin
        if (lt_trig_waiting)                  state_nxt = WAIT_FIN;
        else if (cnt == CW'(TRIG_TIMEOUT - 1)) state_nxt = DONE;
      end
      WAIT_FIN:   if (lt_finished) state_nxt = COLLECT;
      COLLECT:    state_nxt = lat_sat ? DONE : GAP;
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1))
          state_nxt = (runs_done == runs_tgt) ? DONE : ARM;
      end
      default:    state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;

    // Outputs are decoded from the next state so they are registered yet aligned with the state.
    act_nxt  = state_nxt inside {ARM, TRIG, WAIT_FIN, COLLECT, GAP};
    arm_nxt  = state_nxt inside {ARM, TRIG, WAIT_FIN, COLLECT};
    trig_nxt = (state_nxt == TRIG);
    busy_nxt = !(state_nxt inside {IDLE, DONE});
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk27) begin
    if (reset) begin
      state      <= IDLE;
      lt_active  <= 1'b0;
      lt_armed   <= 1'b0;
      lt_trigger <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      lt_active  <= act_nxt;
      lt_armed   <= arm_nxt;
      lt_trigger <= trig_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_ff @(posedge clk27) begin
    if (reset) begin
      cnt       <= '0;
      runs_tgt  <= 4'd0;
      err_trig  <= 1'b0;
      err_sat   <= 1'b0;
      runs_done <= 4'd0;
      lat_min   <= 16'hffff;
      lat_max   <= 16'd0;
      lat_sum   <= 20'd0;
`ifdef LT_STB_STATS_EN
      stb_min   <= 12'hfff;
      stb_max   <= 12'd0;
`endif
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;

      if ((state == IDLE || state == DONE) && state_nxt == ARM) begin
        runs_tgt  <= (num_runs == 4'd0) ? 4'd1 : num_runs;
        err_trig  <= 1'b0;
        err_sat   <= 1'b0;
        runs_done <= 4'd0;
        lat_min   <= 16'hffff;
        lat_max   <= 16'd0;
        lat_sum   <= 20'd0;
`ifdef LT_STB_STATS_EN
        stb_min   <= 12'hfff;
        stb_max   <= 12'd0;
`endif
      end

      if (state == TRIG && state_nxt == DONE) err_trig <= 1'b1;
      if (state == COLLECT && state_nxt == DONE) err_sat <= 1'b1;

      // Gated on the GAP transition so an abort during COLLECT leaves statistics untouched.
      if (state == COLLECT && state_nxt == GAP) begin
        runs_done <= runs_done + 4'd1;
        lat_sum   <= lat_sum + {4'd0, lt_lat_result};
        if (lt_lat_result < lat_min) lat_min <= lt_lat_result;
        if (lt_lat_result > lat_max) lat_max <= lt_lat_result;
`ifdef LT_STB_STATS_EN
        if (lt_stb_result < stb_min) stb_min <= lt_stb_result;
        if (lt_stb_result > stb_max) stb_max <= lt_stb_result;
`endif
      end
    end
  end

`ifndef LT_STB_STATS_EN
  logic unused_stb;
  assign unused_stb = ^lt_stb_result;
`endif

endmodule

// File: tb/tb_lat_meas_seq.sv
// Bench for lat_meas_seq: behavioural lat_tester model plus a scoreboard of expected sequence results.
module tb_lat_meas_seq;

  localparam int GAP = 4;
  localparam int TTO = 8;

  logic        clk27 = 1'b0;
  logic        reset, start, abort;
  logic [3:0]  num_runs;
  logic        lt_active, lt_armed, lt_trigger;
  logic        lt_trig_waiting, lt_finished;
  logic [15:0] lt_lat_result;
  logic [11:0] lt_stb_result;
  logic        busy, done, err_trig, err_sat;
  logic [3:0]  runs_done;
  logic [15:0] lat_min, lat_max;
  logic [19:0] lat_sum;
`ifdef LT_STB_STATS_EN
  logic [11:0] stb_min, stb_max;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        done;
    logic        err_trig;
    logic        err_sat;
    logic [3:0]  runs;
    logic [15:0] lmin;
    logic [15:0] lmax;
    logic [19:0] lsum;
  } res_t;

  res_t exp_q[$];

  always #5 clk27 = ~clk27;

  lat_meas_seq #(.GAP_CYCLES(GAP), .TRIG_TIMEOUT(TTO)) dut (
    .clk27(clk27), .reset(reset), .start(start), .abort(abort), .num_runs(num_runs),
    .lt_active(lt_active), .lt_armed(lt_armed), .lt_trigger(lt_trigger),
    .lt_trig_waiting(lt_trig_waiting), .lt_finished(lt_finished),
    .lt_lat_result(lt_lat_result), .lt_stb_result(lt_stb_result),
    .busy(busy), .done(done), .err_trig(err_trig), .err_sat(err_sat),
    .runs_done(runs_done), .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum)
`ifdef LT_STB_STATS_EN
    , .stb_min(stb_min), .stb_max(stb_max)
`endif
  );

  task automatic tick();
    @(negedge clk27);
  endtask

  function automatic res_t observed();
    res_t r;
    r = {done, err_trig, err_sat, runs_done, lat_min, lat_max, lat_sum};
    return r;
  endfunction

  task automatic pulse_start(input logic [3:0] n);
    num_runs = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // lat_tester model: answers the trigger 3 cycles later, reports a result, clears when disarmed.
  task automatic do_run(input logic [15:0] lat, input logic [11:0] stb, input bit abort_mid);
    int n;
    n = 0;
    while (lt_trigger !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (lt_trigger !== 1'b1) begin
      errors++; $display("FAIL trigger_rise: lt_trigger=%b required 1", lt_trigger);
      return;
    end
    repeat (3) tick();
    lt_trig_waiting = 1'b1;
    tick();
    checks++;
    if ({lt_active, lt_trigger} !== 2'b10) begin
      errors++; $display("FAIL trig_drop: active,trigger=%b required 10", {lt_active, lt_trigger});
    end
    if (abort_mid) begin
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0; lt_trig_waiting = 1'b0;
      return;
    end
    tick();
    lt_lat_result = lat; lt_stb_result = stb; lt_finished = 1'b1;
    tick();
    lt_finished = 1'b0; lt_trig_waiting = 1'b0;
    n = 0;
    while (lt_armed !== 1'b0 && n < 20) begin tick(); n++; end
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL arm_drop_latency: cycles after collect=%0d required 1", n);
    end
    lt_lat_result = 16'd0; lt_stb_result = 12'd0;
  endtask

  // Counts consecutive disarmed cycles until the next arm or done.
  task automatic check_gap(input string name);
    int low;
    logic act_ok;
    low = 0; act_ok = 1'b1;
    while (lt_armed === 1'b0 && done !== 1'b1 && low < 50) begin
      low++; act_ok = act_ok & lt_active; tick();
    end
    checks++;
    if (low != GAP || act_ok !== 1'b1) begin
      errors++; $display("FAIL %s: armed low %0d cycles active=%b, required %0d cycles active=1", name, low, act_ok, GAP);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin tick(); n++; end
  endtask

  task automatic test_reset();
    res_t e;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    e = '{done: 1'b0, err_trig: 1'b0, err_sat: 1'b0, runs: 4'd0, lmin: 16'hffff, lmax: 16'd0, lsum: 20'd0};
    checks++;
    if (observed() !== e) begin
      errors++; $display("FAIL reset_results: got %h required %h", observed(), e);
    end
    checks++;
    if ({lt_active, lt_armed, lt_trigger, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0000", {lt_active, lt_armed, lt_trigger, busy});
    end
  endtask

  task automatic test_three_runs();
    logic [15:0] lats [3] = '{16'd120, 16'd100, 16'd140};
    logic [11:0] stbs [3] = '{12'd150, 12'd130, 12'd170};
    res_t e;
    e = '{done: 1'b1, err_trig: 1'b0, err_sat: 1'b0, runs: 4'd3, lmin: 16'hffff, lmax: 16'd0, lsum: 20'd0};
    for (int i = 0; i < 3; i++) begin
      if (lats[i] < e.lmin) e.lmin = lats[i];
      if (lats[i] > e.lmax) e.lmax = lats[i];
      e.lsum = e.lsum + 20'(lats[i]);
    end
    exp_q.push_back(e);
    pulse_start(4'd3);
    checks++;
    if ({lt_active, lt_armed, lt_trigger, busy} !== 4'b1101) begin
      errors++; $display("FAIL start_timing: act,arm,trig,busy=%b required 1101", {lt_active, lt_armed, lt_trigger, busy});
    end
    tick(); tick();
    checks++;
    if (lt_trigger !== 1'b1) begin
      errors++; $display("FAIL trigger_at_n3: lt_trigger=%b required 1", lt_trigger);
    end
    for (int i = 0; i < 3; i++) begin
      do_run(lats[i], stbs[i], 1'b0);
      check_gap("rearm_gap");
    end
    wait_done();
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++; $display("FAIL three_runs: got %h required %h", observed(), e);
    end
`ifdef LT_STB_STATS_EN
    checks++;
    if ({stb_min, stb_max} !== {12'd130, 12'd170}) begin
      errors++; $display("FAIL stb_stats: got %0d/%0d required 130/170", stb_min, stb_max);
    end
`endif
  endtask

  task automatic test_zero_runs();
    res_t e;
    e = '{done: 1'b1, err_trig: 1'b0, err_sat: 1'b0, runs: 4'd1, lmin: 16'd77, lmax: 16'd77, lsum: 20'd77};
    exp_q.push_back(e);
    pulse_start(4'd0);
    do_run(16'd77, 12'd9, 1'b0);
    check_gap("zero_runs_gap");
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL zero_runs_done: done=%b required 1", done);
    end
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++; $display("FAIL zero_runs: got %h required %h", observed(), e);
    end
  endtask

  task automatic test_trig_timeout();
    res_t e;
    int n;
    e = '{done: 1'b1, err_trig: 1'b1, err_sat: 1'b0, runs: 4'd0, lmin: 16'hffff, lmax: 16'd0, lsum: 20'd0};
    exp_q.push_back(e);
    pulse_start(4'd2);
    n = 0;
    while (lt_trigger !== 1'b1 && n < 40) begin tick(); n++; end
    repeat (TTO - 1) tick();
    checks++;
    if ({done, lt_trigger} !== 2'b01) begin
      errors++; $display("FAIL timeout_early: done,trigger=%b required 01", {done, lt_trigger});
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++; $display("FAIL timeout_done: got %h required %h", observed(), e);
    end
    tick();
    checks++;
    if ({lt_active, lt_trigger} !== 2'b00) begin
      errors++; $display("FAIL timeout_inactive: active,trigger=%b required 00", {lt_active, lt_trigger});
    end
  endtask

  task automatic test_saturated();
    res_t e;
    e = '{done: 1'b1, err_trig: 1'b0, err_sat: 1'b1, runs: 4'd1, lmin: 16'd200, lmax: 16'd200, lsum: 20'd200};
    exp_q.push_back(e);
    pulse_start(4'd4);
    do_run(16'd200, 12'd50, 1'b0);
    check_gap("sat_gap");
    do_run(16'hffff, 12'd60, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++; $display("FAIL saturated: got %h required %h", observed(), e);
    end
  endtask

  task automatic test_abort();
    res_t e;
    e = '{done: 1'b0, err_trig: 1'b0, err_sat: 1'b0, runs: 4'd1, lmin: 16'd300, lmax: 16'd300, lsum: 20'd300};
    exp_q.push_back(e);
    exp_q.push_back(e);
    pulse_start(4'd2);
    do_run(16'd300, 12'd40, 1'b0);
    check_gap("abort_gap");
    do_run(16'd0, 12'd0, 1'b1);
    checks++;
    if ({lt_active, lt_armed, lt_trigger, busy} !== 4'b0000) begin
      errors++; $display("FAIL abort_ctrl: act,arm,trig,busy=%b required 0000", {lt_active, lt_armed, lt_trigger, busy});
    end
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++; $display("FAIL abort_results: got %h required %h", observed(), e);
    end
    repeat (5) tick();
    e = exp_q.pop_front();
    checks++;
    if (busy !== 1'b0 || observed() !== e) begin
      errors++; $display("FAIL abort_no_restart: busy=%b got %h required busy=0 %h", busy, observed(), e);
    end
  endtask

  task automatic test_reset_mid();
    res_t e;
    e = '{done: 1'b0, err_trig: 1'b0, err_sat: 1'b0, runs: 4'd0, lmin: 16'hffff, lmax: 16'd0, lsum: 20'd0};
    pulse_start(4'd5);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (observed() !== e || {lt_active, lt_armed, lt_trigger, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid: got %h ctrl %b required %h ctrl 0000", observed(),
                         {lt_active, lt_armed, lt_trigger, busy}, e);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; num_runs = 4'd0;
    lt_trig_waiting = 1'b0; lt_finished = 1'b0;
    lt_lat_result = 16'd0; lt_stb_result = 12'd0;
    test_reset();
    test_three_runs();
    test_zero_runs();
    test_trig_timeout();
    test_saturated();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
